// File: rtl/gerenciador_balas_pkg.sv
// rtl/gerenciador_balas_pkg.sv - game constants and bullet slot record shared by the projectile blocks
package gerenciador_balas_pkg;

  localparam int X_MAX    = 640;
  localparam int Y_MAX    = 480;
  localparam int OFFSET_Y = 35;
  localparam int RAIO     = 5;

  localparam int COORD_W  = 10;
  localparam int SOMA_W   = COORD_W + 1;
  localparam int IDX_W    = 3;
  localparam int OCUP_W   = 4;

  typedef struct packed {
    logic               ativo;
    logic               aliada;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } bala_t;

  typedef enum logic {
    LADO_JOG = 1'b0,
    LADO_INI = 1'b1
  } lado_t;

endpackage

// File: rtl/gerenciador_balas_divisor_tick.sv
// rtl/gerenciador_balas_divisor_tick.sv - movement tick divider with enable and synchronous clear
module divisor_tick #(
  parameter int DIV = 100000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic limpar,
  input  logic habilita,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] contador;

  // Holding the count while disabled preserves the tick phase across a pause.
  assign tick = habilita && (contador == ULTIMO);

  always_ff @(posedge CLOCK_50) begin
    if (reset || limpar) begin
      contador <= '0;
    end else if (tick) begin
      contador <= '0;
    end else if (habilita) begin
      contador <= contador + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gerenciador_balas.sv
// rtl/gerenciador_balas.sv - bullet slot pool: fire arbitration, movement, retirement and query port
module gerenciador_balas
  import gerenciador_balas_pkg::*;
#(
  parameter int N_BALAS  = 4,
  parameter int TICK_DIV = 100000
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                pausa,
  input  logic                reiniciarJogo,
  input  logic                req_jog,
  input  logic [COORD_W-1:0]  xi_jog,
  input  logic [COORD_W-1:0]  yi_jog,
  output logic                ack_jog,
  output logic                neg_jog,
  input  logic                req_ini,
  input  logic [COORD_W-1:0]  xi_ini,
  input  logic [COORD_W-1:0]  yi_ini,
  output logic                ack_ini,
  output logic                neg_ini,
  input  logic                acerto,
  input  logic [IDX_W-1:0]    acerto_idx,
  input  logic [IDX_W-1:0]    cons_idx,
  output logic                cons_ativo,
  output logic                cons_aliada,
  output logic [COORD_W-1:0]  cons_x,
  output logic [COORD_W-1:0]  cons_y,
  output logic [OCUP_W-1:0]   ocupacao,
  output logic [COORD_W-1:0]  raio
);

  bala_t slots   [N_BALAS];
  bala_t slots_n [N_BALAS];
  bala_t novo;
  bala_t cons_n;
  bala_t cons_q;

  logic              rr_ini, rr_ini_n;
  logic              ack_jog_n, neg_jog_n, ack_ini_n, neg_ini_n;
  logic              tick;
  logic              livre_ok;
  logic [IDX_W-1:0]  livre_idx;
  logic [SOMA_W-1:0] y_ini_soma;
  logic              jog_ok, ini_ok;
  logic              atender, aceita;
  lado_t             lado;

  divisor_tick #(
    .DIV (TICK_DIV)
  ) u_divisor_tick (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .limpar   (reiniciarJogo),
    .habilita (!pausa),
    .tick     (tick)
  );

  assign y_ini_soma = {1'b0, yi_ini} + SOMA_W'(OFFSET_Y);
  assign jog_ok     = yi_jog >= COORD_W'(OFFSET_Y);
  assign ini_ok     = y_ini_soma < SOMA_W'(Y_MAX);

  // Lowest free slot from registered state, so a slot retired this cycle is not reused yet.
  always_comb begin
    livre_ok  = 1'b0;
    livre_idx = '0;
    for (int i = N_BALAS - 1; i >= 0; i--) begin
      if (!slots[i].ativo) begin
        livre_ok  = 1'b1;
        livre_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lado = LADO_JOG;
    if (req_jog && req_ini) begin
      lado = rr_ini ? LADO_INI : LADO_JOG;
    end else if (req_ini) begin
      lado = LADO_INI;
    end
    atender = !pausa && !reiniciarJogo && (req_jog || req_ini);
    aceita  = atender && livre_ok && ((lado == LADO_INI) ? ini_ok : jog_ok);

    novo = '0;
    novo.ativo = 1'b1;
    if (lado == LADO_INI) begin
      novo.aliada = 1'b0;
      novo.x      = xi_ini;
      novo.y      = y_ini_soma[COORD_W-1:0];
    end else begin
      novo.aliada = 1'b1;
      novo.x      = xi_jog;
      novo.y      = yi_jog - COORD_W'(OFFSET_Y);
    end

    ack_jog_n = aceita && (lado == LADO_JOG);
    neg_jog_n = atender && !aceita && (lado == LADO_JOG);
    ack_ini_n = aceita && (lado == LADO_INI);
    neg_ini_n = atender && !aceita && (lado == LADO_INI);
    rr_ini_n  = atender ? (lado == LADO_JOG) : rr_ini;
  end

  // A fresh slot skips this cycle's move; a collision beats a move on the same slot.
  always_comb begin
    for (int i = 0; i < N_BALAS; i++) begin
      slots_n[i] = slots[i];
      if (aceita && (livre_idx == IDX_W'(i))) begin
        slots_n[i] = novo;
      end else if (slots[i].ativo) begin
        if (acerto && (acerto_idx == IDX_W'(i))) begin
          slots_n[i] = '0;
        end else if (tick) begin
          if (slots[i].aliada) begin
            if (slots[i].y == '0) slots_n[i] = '0;
            else                  slots_n[i].y = slots[i].y - COORD_W'(1);
          end else begin
            if (({1'b0, slots[i].y} + SOMA_W'(1)) >= SOMA_W'(Y_MAX)) slots_n[i] = '0;
            else slots_n[i].y = slots[i].y + COORD_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    cons_n   = '0;
    ocupacao = '0;
    for (int i = 0; i < N_BALAS; i++) begin
      if (cons_idx == IDX_W'(i)) cons_n = slots[i];
      ocupacao = ocupacao + OCUP_W'(slots[i].ativo);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || reiniciarJogo) begin
      for (int i = 0; i < N_BALAS; i++) slots[i] <= '0;
      rr_ini  <= 1'b0;
      ack_jog <= 1'b0;
      neg_jog <= 1'b0;
      ack_ini <= 1'b0;
      neg_ini <= 1'b0;
    end else begin
      for (int i = 0; i < N_BALAS; i++) slots[i] <= slots_n[i];
      rr_ini  <= rr_ini_n;
      ack_jog <= ack_jog_n;
      neg_jog <= neg_jog_n;
      ack_ini <= ack_ini_n;
      neg_ini <= neg_ini_n;
    end
    // The query register keeps running through reiniciarJogo; only reset zeroes it.
    if (reset) cons_q <= '0;
    else       cons_q <= cons_n;
  end

  assign cons_ativo  = cons_q.ativo;
  assign cons_aliada = cons_q.aliada;
  assign cons_x      = cons_q.x;
  assign cons_y      = cons_q.y;
  assign raio        = COORD_W'(RAIO);

endmodule

// File: tb/tb_gerenciador_balas.sv
// tb/tb_gerenciador_balas.sv - directed scoreboard bench for the bullet pool controller
module tb_gerenciador_balas;

  logic       CLOCK_50 = 1'b0;
  logic       reset, pausa, reiniciarJogo;
  logic       req_jog, req_ini, acerto;
  logic [9:0] xi_jog, yi_jog, xi_ini, yi_ini;
  logic [2:0] acerto_idx, cons_idx;
  logic       ack_jog, neg_jog, ack_ini, neg_ini;
  logic       cons_ativo, cons_aliada;
  logic [9:0] cons_x, cons_y, raio;
  logic [3:0] ocupacao;

  always #5 CLOCK_50 = ~CLOCK_50;

  gerenciador_balas #(.N_BALAS(4), .TICK_DIV(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa), .reiniciarJogo(reiniciarJogo),
    .req_jog(req_jog), .xi_jog(xi_jog), .yi_jog(yi_jog), .ack_jog(ack_jog), .neg_jog(neg_jog),
    .req_ini(req_ini), .xi_ini(xi_ini), .yi_ini(yi_ini), .ack_ini(ack_ini), .neg_ini(neg_ini),
    .acerto(acerto), .acerto_idx(acerto_idx), .cons_idx(cons_idx),
    .cons_ativo(cons_ativo), .cons_aliada(cons_aliada), .cons_x(cons_x), .cons_y(cons_y),
    .ocupacao(ocupacao), .raio(raio)
  );

  // Handshake codes as {ack_jog, neg_jog, ack_ini, neg_ini}
  localparam int HS_NONE = 0, HS_ACK_JOG = 8, HS_NEG_JOG = 4, HS_ACK_INI = 2, HS_NEG_INI = 1;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   phase    = 0;
  int   ticks    = 0;
  int   t0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit tk;
    tk = !reset && !reiniciarJogo && !pausa && (phase == 3);
    @(posedge CLOCK_50);
    #1;
    if (reset || reiniciarJogo) phase = 0;
    else if (!pausa)            phase = (phase + 1) % 4;
    if (tk) ticks++;
  endtask

  task automatic push_exp(input string tag, input int v);
    sb.push_back('{tag, v});
  endtask

  task automatic pop_check(input int obs);
    exp_t e;
    n_checks++;
    assert (sb.size() > 0) else begin
      n_err++;
      $error("FAIL sb_underflow: observed=%0d expected=queued entry", obs);
    end
    if (sb.size() > 0) begin
      n_checks--;
      e = sb.pop_front();
      chk(e.tag, obs, e.val);
    end
  endtask

  function automatic int hs();
    return int'({ack_jog, neg_jog, ack_ini, neg_ini});
  endfunction

  task automatic fire_jog(input int x, input int y, input int exp_hs);
    xi_jog = 10'(x); yi_jog = 10'(y); req_jog = 1'b1;
    push_exp($sformatf("hs_jog_y%0d", y), exp_hs);
    step();
    req_jog = 1'b0;
    pop_check(hs());
  endtask

  task automatic fire_ini(input int x, input int y, input int exp_hs);
    xi_ini = 10'(x); yi_ini = 10'(y); req_ini = 1'b1;
    push_exp($sformatf("hs_ini_y%0d", y), exp_hs);
    step();
    req_ini = 1'b0;
    pop_check(hs());
  endtask

  task automatic read_slot(input int k, input int at, input int al, input int x, input int y);
    cons_idx = 3'(k);
    push_exp($sformatf("s%0d_ativo", k), at);
    push_exp($sformatf("s%0d_aliada", k), al);
    push_exp($sformatf("s%0d_x", k), x);
    push_exp($sformatf("s%0d_y", k), y);
    step();
    pop_check(int'(cons_ativo));
    pop_check(int'(cons_aliada));
    pop_check(int'(cons_x));
    pop_check(int'(cons_y));
  endtask

  task automatic read_ativo(input int k, input int at);
    cons_idx = 3'(k);
    push_exp($sformatf("s%0d_ativo", k), at);
    step();
    pop_check(int'(cons_ativo));
  endtask

  task automatic wait_ticks(input int n);
    int alvo;
    alvo = ticks + n;
    while (ticks < alvo) step();
  endtask

  task automatic reiniciar();
    reiniciarJogo = 1'b1;
    step();
    reiniciarJogo = 1'b0;
  endtask

  task automatic hit(input int k);
    acerto = 1'b1; acerto_idx = 3'(k);
    step();
    acerto = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int bad;
    reset = 1'b1; pausa = 1'b0; reiniciarJogo = 1'b0;
    req_jog = 1'b0; req_ini = 1'b0; acerto = 1'b0;
    xi_jog = '0; yi_jog = '0; xi_ini = '0; yi_ini = '0;
    acerto_idx = '0; cons_idx = '0;

    // Reset state
    step(); step();
    chk("rst_hs", hs(), HS_NONE);
    chk("rst_ocupacao", int'(ocupacao), 0);
    chk("rst_cons_ativo", int'(cons_ativo), 0);
    chk("rst_cons_x", int'(cons_x), 0);
    chk("rst_cons_y", int'(cons_y), 0);
    chk("raio", int'(raio), 5);
    reset = 1'b0;

    // Single player shot, then three ticks of upward motion
    fire_jog(100, 400, HS_ACK_JOG);
    read_slot(0, 1, 1, 100, 365);
    wait_ticks(3);
    read_slot(0, 1, 1, 100, 362);
    chk("ocup_one", int'(ocupacao), 1);

    // Simultaneous requests: player first, enemy on the next cycle
    reiniciar();
    xi_jog = 10'd100; yi_jog = 10'd400; xi_ini = 10'd200; yi_ini = 10'd50;
    req_jog = 1'b1; req_ini = 1'b1;
    push_exp("both_first", HS_ACK_JOG);
    step();
    req_jog = 1'b0;
    pop_check(hs());
    push_exp("both_second", HS_ACK_INI);
    step();
    req_ini = 1'b0;
    pop_check(hs());
    read_slot(0, 1, 1, 100, 365);
    read_slot(1, 1, 0, 200, 85);
    chk("ocup_two", int'(ocupacao), 2);

    // Fill the pool, deny when full, recycle a collided slot
    fire_jog(300, 400, HS_ACK_JOG);
    fire_jog(310, 400, HS_ACK_JOG);
    t0 = ticks;
    chk("ocup_full", int'(ocupacao), 4);
    fire_jog(320, 400, HS_NEG_JOG);
    fire_ini(330, 100, HS_NEG_INI);
    chk("ocup_full_after_neg", int'(ocupacao), 4);
    read_slot(3, 1, 1, 310, 365 - (ticks - t0));
    hit(2);
    chk("ocup_after_hit", int'(ocupacao), 3);
    fire_jog(400, 400, HS_ACK_JOG);
    t0 = ticks;
    read_slot(2, 1, 1, 400, 365 - (ticks - t0));

    // Screen-edge retirement and spawn-range boundaries
    reiniciar();
    fire_ini(50, 443, HS_ACK_INI);
    wait_ticks(1);
    read_slot(0, 1, 0, 50, 479);
    wait_ticks(1);
    chk("ocup_ini_retired", int'(ocupacao), 0);
    fire_jog(60, 35, HS_ACK_JOG);
    read_slot(0, 1, 1, 60, 0);
    wait_ticks(1);
    chk("ocup_jog_retired", int'(ocupacao), 0);
    fire_jog(70, 20, HS_NEG_JOG);
    fire_ini(80, 445, HS_NEG_INI);
    fire_ini(80, 444, HS_ACK_INI);
    chk("ocup_ini_edge", int'(ocupacao), 1);

    // Pause: frozen positions, held request waits, tick phase preserved
    reiniciar();
    fire_jog(100, 400, HS_ACK_JOG);
    step();
    pausa = 1'b1;
    xi_jog = 10'd110; yi_jog = 10'd400; req_jog = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (hs() != HS_NONE) bad++;
    end
    chk("pause_no_handshake", bad, 0);
    read_slot(0, 1, 1, 100, 365);
    pausa = 1'b0;
    push_exp("pause_release_ack", HS_ACK_JOG);
    step();
    req_jog = 1'b0;
    pop_check(hs());
    while (phase != 3) step();
    read_slot(0, 1, 1, 100, 365);
    read_slot(0, 1, 1, 100, 364);

    // Collision on a tick cycle retires instead of moving
    while (phase != 3) step();
    hit(0);
    read_ativo(0, 0);
    chk("ocup_hit_on_tick", int'(ocupacao), 1);

    // Restart with three active slots and requests pending
    fire_jog(120, 400, HS_ACK_JOG);
    fire_jog(130, 400, HS_ACK_JOG);
    fire_jog(140, 400, HS_ACK_JOG);
    hit(3);
    chk("ocup_three", int'(ocupacao), 3);
    xi_jog = 10'd150; yi_jog = 10'd400; xi_ini = 10'd160; yi_ini = 10'd100;
    req_jog = 1'b1; req_ini = 1'b1; reiniciarJogo = 1'b1;
    push_exp("restart_no_handshake", HS_NONE);
    step();
    reiniciarJogo = 1'b0;
    pop_check(hs());
    chk("ocup_restart", int'(ocupacao), 0);
    push_exp("restart_player_first", HS_ACK_JOG);
    step();
    req_jog = 1'b0;
    pop_check(hs());
    push_exp("restart_enemy_next", HS_ACK_INI);
    step();
    req_ini = 1'b0;
    pop_check(hs());

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
